// File: rtl/register_file_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : register_file_dump_controller
// Purpose  : Debug sequencer that freezes the CPU pipeline, walks register
//            file read port A through every address and serialises each word
//            MSB-byte first onto a valid/ready byte stream. The pipeline is
//            released once the last register has been sent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature:
//   DUMP_HEADER_EN - when defined, the stream is prefixed with two header
//                    bytes (0xA5, then RAM_DEPTH-1) before the first register.
// ----------------------------------------------------------------------------
// Parameters:
//   NB_ADDR    register file address width
//   NB_DATA    register width, multiple of 8
//   RAM_DEPTH  number of registers dumped
// Ports:
//   i_clock         clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_dump_start    dump request (only honoured while idle)
//   o_stall_req     pipeline freeze request / read-port-A mux select
//   i_stall_ack     pipeline frozen, no register write pending
//   o_rf_read_addr  register file read address (registered)
//   i_rf_data       register file read data (combinational)
//   o_byte          stream byte
//   o_byte_valid    stream valid
//   i_byte_ready    stream ready
//   o_busy          high whenever the sequencer is not idle
//   o_done          one-cycle pulse at the end of a dump
// ============================================================================
module register_file_dump_controller #(
  parameter int NB_ADDR   = 5,
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 2**NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_dump_start,
  output logic               o_stall_req,
  input  logic               i_stall_ack,
  output logic [NB_ADDR-1:0] o_rf_read_addr,
  input  logic [NB_DATA-1:0] i_rf_data,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid,
  input  logic               i_byte_ready,
  output logic               o_busy,
  output logic               o_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int NB_BYTES = NB_DATA / 8;
  // Byte counter needs at least one bit: the header also counts 0..1 with it.
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_ADDR-1:0] c_last_addr = NB_ADDR'(RAM_DEPTH - 1);
  localparam logic [NB_CNT-1:0]  c_last_byte = NB_CNT'(NB_BYTES - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_halt   = 3'd1;
  localparam logic [2:0] c_st_read   = 3'd2;
  localparam logic [2:0] c_st_send   = 3'd3;
  localparam logic [2:0] c_st_done   = 3'd4;
`ifdef DUMP_HEADER_EN
  localparam logic [2:0] c_st_header = 3'd5;

  localparam logic [7:0]        c_hdr_magic    = 8'hA5;
  // Second header byte is the last address; truncated if RAM_DEPTH > 256.
  localparam logic [7:0]        c_hdr_last     = 8'(RAM_DEPTH - 1);
  localparam logic [NB_CNT-1:0] c_hdr_last_idx = NB_CNT'(1);
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]         state_q, state_d;
  logic [NB_ADDR-1:0] addr_q,  addr_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q,   cnt_d;
`ifdef DUMP_HEADER_EN
  // Set once the header has gone out, so an ack drop during READ (which
  // sends the FSM back through HALT) does not resend the header.
  logic               hdr_done_q, hdr_done_d;
`endif

  // --------------------------------------------------------------------------
  // Handshake helpers
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_last_byte;
  logic w_last_addr;

  assign w_accept    = o_byte_valid & i_byte_ready;
  assign w_last_byte = (cnt_q == c_last_byte);
  assign w_last_addr = (addr_q == c_last_addr);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (i_dump_start) begin
          state_d = c_st_halt;
        end
      end
      c_st_halt: begin
        if (i_stall_ack) begin
`ifdef DUMP_HEADER_EN
          state_d = hdr_done_q ? c_st_read : c_st_header;
`else
          state_d = c_st_read;
`endif
        end
      end
`ifdef DUMP_HEADER_EN
      c_st_header: begin
        if (w_accept && (cnt_q == c_hdr_last_idx)) begin
          state_d = c_st_read;
        end
      end
`endif
      c_st_read: begin
        // Losing the ack here means a write may be in flight: re-freeze
        // and read the same address again once the pipeline is quiet.
        state_d = i_stall_ack ? c_st_send : c_st_halt;
      end
      c_st_send: begin
        // The ack is deliberately ignored here; the captured word is
        // already safe in the shift register and is always completed.
        if (w_accept && w_last_byte) begin
          state_d = w_last_addr ? c_st_done : c_st_read;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state logic (address, shift register, byte counter)
  // --------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
`ifdef DUMP_HEADER_EN
    hdr_done_d = hdr_done_q;
`endif
    case (state_q)
      c_st_idle: begin
        cnt_d = '0;
      end
      c_st_halt: begin
        cnt_d = '0;
      end
`ifdef DUMP_HEADER_EN
      c_st_header: begin
        if (w_accept) begin
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == c_hdr_last_idx) begin
            cnt_d      = '0;
            hdr_done_d = 1'b1;
          end
        end
      end
`endif
      c_st_read: begin
        if (i_stall_ack) begin
          shift_d = i_rf_data;
          cnt_d   = '0;
        end
      end
      c_st_send: begin
        if (w_accept) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + NB_CNT'(1);
          // The final address is held through DONE; it only returns to
          // zero when DONE hands back to IDLE.
          if (w_last_byte && !w_last_addr) begin
            addr_d = addr_q + NB_ADDR'(1);
          end
        end
      end
      c_st_done: begin
        addr_d     = '0;
`ifdef DUMP_HEADER_EN
        hdr_done_d = 1'b0;
`endif
      end
      default: begin
        addr_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
`ifdef DUMP_HEADER_EN
      hdr_done_q <= 1'b0;
`endif
    end else begin
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
`ifdef DUMP_HEADER_EN
      hdr_done_q <= hdr_done_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // All outputs decode from registered state, so the asynchronous reset
  // forces them low immediately and valid/byte cannot change between edges.
  // --------------------------------------------------------------------------
  always_comb begin
    o_stall_req    = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_byte_valid   = 1'b0;
    o_byte         = 8'h00;
    o_rf_read_addr = addr_q;
    case (state_q)
      c_st_idle: begin
        o_stall_req = 1'b0;
      end
      c_st_halt: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
      end
`ifdef DUMP_HEADER_EN
      c_st_header: begin
        o_stall_req  = 1'b1;
        o_busy       = 1'b1;
        o_byte_valid = 1'b1;
        o_byte       = (cnt_q == '0) ? c_hdr_magic : c_hdr_last;
      end
`endif
      c_st_read: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
      end
      c_st_send: begin
        o_stall_req  = 1'b1;
        o_busy       = 1'b1;
        o_byte_valid = 1'b1;
        o_byte       = shift_q[NB_DATA-1 -: 8];
      end
      c_st_done: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
        o_done      = 1'b1;
      end
      default: begin
        o_stall_req = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_dump_controller
// Purpose  : Self-checking bench for register_file_dump_controller. A model
//            register file feeds read port A; every dump pushes its expected
//            byte stream into a scoreboard queue which is popped on each
//            accepted byte. Honours DUMP_HEADER_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_dump_controller;

  localparam int NB_ADDR   = 5;
  localparam int NB_DATA   = 32;
  localparam int RAM_DEPTH = 32;
  localparam int NB_BYTES  = NB_DATA / 8;
`ifdef DUMP_HEADER_EN
  localparam int DUMP_CYCLES  = 164;
  localparam int STREAM_BYTES = RAM_DEPTH * NB_BYTES + 2;
  localparam int ACK_TO_BYTE  = 1;
`else
  localparam int DUMP_CYCLES  = 162;
  localparam int STREAM_BYTES = RAM_DEPTH * NB_BYTES;
  localparam int ACK_TO_BYTE  = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dump_start;
  logic               stall_req;
  logic               stall_ack;
  logic [NB_ADDR-1:0] rf_addr;
  logic [NB_DATA-1:0] rf_data;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               byte_ready;
  logic               busy;
  logic               done;

  logic [NB_DATA-1:0] rf [RAM_DEPTH];
  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  register_file_dump_controller #(
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_dump_start   (dump_start),
    .o_stall_req    (stall_req),
    .i_stall_ack    (stall_ack),
    .o_rf_read_addr (rf_addr),
    .i_rf_data      (rf_data),
    .o_byte         (byte_out),
    .o_byte_valid   (byte_valid),
    .i_byte_ready   (byte_ready),
    .o_busy         (busy),
    .o_done         (done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_popped = 0;
  logic [7:0] exp_q [$];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream for one full dump of the model register file.
  task automatic push_dump();
    logic [NB_DATA-1:0] w;
`ifdef DUMP_HEADER_EN
    logic [7:0] hdr_last;
    hdr_last = 8'(RAM_DEPTH - 1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(hdr_last);
`endif
    for (int k = 0; k < RAM_DEPTH; k++) begin
      w = rf[k];
      for (int b = NB_BYTES - 1; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
      end
    end
    n_popped = 0;
  endtask

  // One clock: score any byte accepted at this edge, then check that a
  // stalled byte was held. Called 1 time unit after an edge with inputs set.
  task automatic cyc();
    logic       acc;
    logic       hold;
    logic [7:0] b;
    acc  = byte_valid && byte_ready;
    hold = byte_valid && !byte_ready;
    b    = byte_out;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk_eq("extra_byte", 32'd1, 32'd0);
      end else begin
        chk_eq("stream_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
      n_popped++;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk_eq("hold_valid", {31'd0, byte_valid}, 32'd1);
      chk_eq("hold_byte", {24'd0, byte_out}, {24'd0, b});
    end
  endtask

  task automatic check_end(input string tag);
    chk_eq({tag, "_bytes"}, n_popped, STREAM_BYTES);
    chk_eq({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Dump with ack and ready tied high; checks the o_done position exactly.
  task automatic full_dump(input string tag);
    int cnt;
    stall_ack  = 1'b1;
    byte_ready = 1'b1;
    push_dump();
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    chk_eq({tag, "_stall_after_start"}, {31'd0, stall_req}, 32'd1);
    chk_eq({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    cnt = 0;
    while (!done && cnt < 400) begin
      cyc();
      cnt++;
    end
    // cnt edges after the start edge; o_done is visible in cycle cnt+1.
    chk_eq({tag, "_done_cycle"}, cnt + 1, DUMP_CYCLES);
    check_end(tag);
    cyc();
    chk_eq({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
    chk_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk_eq({tag, "_stall_end"}, {31'd0, stall_req}, 32'd0);
    chk_eq({tag, "_addr_end"}, {27'd0, rf_addr}, 32'd0);
  endtask

  initial begin
    int  cnt;
    bit  dropped;

    for (int k = 0; k < RAM_DEPTH; k++) begin
      rf[k] = 32'h0100_0000 * k + k;
    end
    rst_n      = 1'b0;
    dump_start = 1'b0;
    stall_ack  = 1'b0;
    byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---------------- reset state ----------------
    chk_eq("rst_stall", {31'd0, stall_req}, 32'd0);
    chk_eq("rst_addr", {27'd0, rf_addr}, 32'd0);
    chk_eq("rst_byte", {24'd0, byte_out}, 32'd0);
    chk_eq("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // ---------------- tied ack/ready dump ----------------
    full_dump("tied");

    // ---------------- ack withheld, then random ready ----------------
    stall_ack  = 1'b0;
    byte_ready = 1'b1;
    push_dump();
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_eq("noack_valid", {31'd0, byte_valid}, 32'd0);
      chk_eq("noack_stall", {31'd0, stall_req}, 32'd1);
    end
    chk_eq("noack_addr", {27'd0, rf_addr}, 32'd0);
    stall_ack = 1'b1;
    cnt = 0;
    while (!byte_valid && cnt < 20) begin
      cyc();
      cnt++;
    end
    chk_eq("ack_to_first_byte", cnt, ACK_TO_BYTE);
    cnt = 0;
    while (!done && cnt < 3000) begin
      byte_ready = 1'($urandom_range(0, 1));
      cyc();
      cnt++;
    end
    chk_eq("random_ready_done", {31'd0, done}, 32'd1);
    check_end("random_ready");
    byte_ready = 1'b1;
    cyc();

    // ---------------- ack dropped during READ of address 7 ----------------
    stall_ack  = 1'b1;
    byte_ready = 1'b1;
    push_dump();
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    dropped = 1'b0;
    cnt = 0;
    while (!done && cnt < 600) begin
      if (!dropped && busy && !byte_valid && rf_addr == NB_ADDR'(7)) begin
        dropped   = 1'b1;
        stall_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
          cyc();
          chk_eq("ackdrop_valid", {31'd0, byte_valid}, 32'd0);
          chk_eq("ackdrop_addr", {27'd0, rf_addr}, 32'd7);
          chk_eq("ackdrop_stall", {31'd0, stall_req}, 32'd1);
        end
        stall_ack = 1'b1;
      end else begin
        cyc();
      end
      cnt++;
    end
    chk_eq("ackdrop_seen", {31'd0, dropped}, 32'd1);
    chk_eq("ackdrop_done", {31'd0, done}, 32'd1);
    check_end("ackdrop");
    cyc();

    // ---------------- reset during SEND of address 12 ----------------
    push_dump();
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    cnt = 0;
    while (!(byte_valid && rf_addr == NB_ADDR'(12)) && cnt < 400) begin
      cyc();
      cnt++;
    end
    chk_eq("reached_addr12", {27'd0, rf_addr}, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst_stall", {31'd0, stall_req}, 32'd0);
    chk_eq("async_rst_addr", {27'd0, rf_addr}, 32'd0);
    chk_eq("async_rst_byte", {24'd0, byte_out}, 32'd0);
    chk_eq("async_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("async_rst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    full_dump("restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/register_file_dump_controller.md
# register_file_dump_controller

Debug sequencer that reads out the whole register file of the pipelined CPU over a byte stream. On a dump request it freezes the pipeline, then walks read port A through every address. It serialises each word MSB-byte first to the debug/UART transmitter and releases the pipeline when done. Sits between the debug unit, the pipeline stall logic and the register file read-port-A mux.

## Interface
- NB_ADDR, 5, register file address width
- NB_DATA, 32, register width; must be a multiple of 8
- RAM_DEPTH, 2**NB_ADDR, number of registers dumped
- i_clock  in  1  clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_dump_start  in  1  dump request, sampled in IDLE only
- o_stall_req  out  1  pipeline freeze request; top level also uses it to mux o_rf_read_addr onto read port A
- i_stall_ack  in  1  pipeline frozen, no register write pending
- o_rf_read_addr  out  NB_ADDR  register file read address
- i_rf_data  in  NB_DATA  register file read data (combinational, same cycle)
- o_byte  out  8  stream byte
- o_byte_valid  out  1  stream valid
- i_byte_ready  in  1  stream ready from transmitter
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of dump

## Operation
- Registered FSM with states IDLE, HALT, READ, SEND and DONE.
- IDLE:
  - i_dump_start=1 goes to HALT.
  - i_dump_start is ignored in all other states.
- HALT:
  - o_stall_req=1.
  - If i_stall_ack=1, go to READ.
  - Otherwise stay in HALT indefinitely.
- READ:
  - If i_stall_ack=1, load i_rf_data into the shift register, clear the byte counter and go to SEND.
  - If i_stall_ack=0, return to HALT with the address unchanged.
- SEND:
  - o_byte_valid=1; o_byte = shift register bits [NB_DATA-1 : NB_DATA-8].
  - On a cycle with o_byte_valid & i_byte_ready, shift left by 8 and increment the byte counter.
  - After byte NB_DATA/8-1 is accepted:
    - if the address is RAM_DEPTH-1, go to DONE;
    - otherwise increment the address and go to READ.
  - The address wraps to 0 only through DONE.
- DONE:
  - o_done=1 for one cycle; o_stall_req and o_busy deassert on the transition to IDLE; clear the address to 0.
- Stream rule:
  - o_byte and o_byte_valid are held stable until accepted.
  - o_byte_valid never drops without acceptance, except on reset.
- Register 0 is dumped like any other register, whatever value it returns.
- i_stall_ack changes during SEND are ignored; the captured word is always completed.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; o_stall_req=0, o_rf_read_addr=0, o_byte=0, o_byte_valid=0, o_busy=0, o_done=0.
  - Shift register and byte counter clear.
- Reset mid-dump aborts immediately. Any partially sent word is lost and o_done is not pulsed.
- Start sampled at edge N → o_stall_req=1 and o_busy=1 after edge N.
- i_stall_ack=1 sampled in HALT → READ for 1 cycle → SEND on the following edge.
- With ready tied high, each register takes 1 READ cycle plus NB_DATA/8 SEND cycles: 5 cycles at default parameters.
- Full dump at default parameters with immediate ack and ready: 1 HALT + 160 + 1 DONE = 162 cycles after start is sampled.
- o_rf_read_addr is registered and stable throughout READ and SEND.

## Configuration
- DUMP_HEADER_EN defined:
  - After HALT, the FSM enters a HEADER state that sends byte 0xA5, then byte RAM_DEPTH-1, before the first READ.
  - Both header bytes follow the same valid/ready rules.
  - Default dump length becomes 164 cycles.
- DUMP_HEADER_EN undefined:
  - No HEADER state; the stream carries only register bytes.
  - Behaviour and cycle counts are exactly as above.

## Test plan
- Register file preloaded with reg[k]=32'h0100_0000*k+k, ready and ack tied high, pulse start → 128 bytes, starting 00,00,00,00,01,00,00,01. o_done pulses exactly 162 cycles after start.
- Ack withheld for 10 cycles → FSM stays in HALT and o_byte_valid stays 0. Once ack=1, the first byte appears 2 cycles later.
- i_byte_ready toggled pseudo-randomly → o_byte stable while valid & !ready. Byte sequence identical to the tied-ready run; no bytes duplicated or dropped.
- i_stall_ack dropped during READ of address 7 → FSM returns to HALT. It re-reads address 7 after ack returns, and the stream is unbroken.
- Reset asserted during SEND of address 12 → all outputs 0 asynchronously. A new start restarts the dump from address 0.
- With DUMP_HEADER_EN defined → first two bytes are A5 and 1F, followed by the register bytes; o_done pulses at cycle 164.
